// File: rtl/fib_sched.sv
// Round-robin scheduler sharing one fib engine between NREQ requesters.
// Define FIB_SCHED_STATS_EN to add the saturating completed-job counter o_job_cnt.
module fib_sched #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [NREQ-1:0]       i_req,
  input  logic [NREQ*WIDTH-1:0] i_n,
  output logic [NREQ-1:0]       o_ack,
  output logic [NREQ-1:0]       o_done,
  output logic [WIDTH-1:0]      o_result,
  output logic                  o_busy,
  output logic                  o_eng_stb,
  output logic [WIDTH-1:0]      o_eng_n,
  input  logic                  i_eng_busy,
  input  logic [WIDTH-1:0]      i_eng_fib
`ifdef FIB_SCHED_STATS_EN
  ,
  output logic [15:0]           o_job_cnt
`endif
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]   grant_q, grant_d;
  logic [NREQ-1:0] ack_d, done_d;
  logic [WIDTH-1:0] result_d, eng_n_d;
  logic            busy_d, stb_d;
  logic [PW-1:0]   sel;
  logic            found;

  // First requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = 32'(rr_ptr_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && i_req[idx]) begin
        found = 1'b1;
        sel   = PW'(idx);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    ack_d    = '0;
    done_d   = '0;
    result_d = o_result;
    eng_n_d  = o_eng_n;
    stb_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found && !i_eng_busy) begin
          grant_d    = sel;
          eng_n_d    = i_n[32'(sel)*WIDTH +: WIDTH];
          stb_d      = 1'b1;
          ack_d[sel] = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (!i_eng_busy) begin
          result_d        = i_eng_fib;
          done_d[grant_q] = 1'b1;
          rr_ptr_d        = (grant_q == PW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Registered busy mirrors the state being entered, so o_busy == (state != IDLE).
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      o_ack     <= '0;
      o_done    <= '0;
      o_result  <= '0;
      o_busy    <= 1'b0;
      o_eng_stb <= 1'b0;
      o_eng_n   <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      o_ack     <= ack_d;
      o_done    <= done_d;
      o_result  <= result_d;
      o_busy    <= busy_d;
      o_eng_stb <= stb_d;
      o_eng_n   <= eng_n_d;
    end
  end

`ifdef FIB_SCHED_STATS_EN
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_job_cnt <= '0;
    end else if (|done_d && o_job_cnt != '1) begin
      o_job_cnt <= o_job_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fib_sched.sv
// Randomized bench for fib_sched with a behavioural fib engine and a job-level scheduler model.
module tb_fib_sched;
  localparam int unsigned NREQ = 4;
  localparam int unsigned W    = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] nbus;
  logic [NREQ-1:0]   ack, done;
  logic [W-1:0]      result, eng_n, eng_fib;
  logic              busy, eng_stb, eng_busy, ext_busy;
  logic [W-1:0]      eng_cnt, eng_nq;
`ifdef FIB_SCHED_STATS_EN
  logic [15:0]       job_cnt;
`endif

  int checks = 0;
  int failures = 0;
  int unsigned ptr_m = 0;
  int unsigned jobs_m = 0;
  int unsigned opm [NREQ];

  always #5 clk = ~clk;

  fib_sched #(.NREQ(NREQ), .WIDTH(W)) dut (
    .i_clk(clk), .i_reset(reset), .i_req(req), .i_n(nbus),
    .o_ack(ack), .o_done(done), .o_result(result), .o_busy(busy),
    .o_eng_stb(eng_stb), .o_eng_n(eng_n),
    .i_eng_busy(eng_busy | ext_busy), .i_eng_fib(eng_fib)
`ifdef FIB_SCHED_STATS_EN
    , .o_job_cnt(job_cnt)
`endif
  );

  function automatic logic [W-1:0] fib_ref(input logic [W-1:0] n);
    case (n)
      0: return 32'h0;
      1: return 32'hFFFFFFFD;
      2: return 32'h00000015;
      3: return 32'h00000162;
      default: return 32'hA5A50000 ^ (n * 32'h00010203);
    endcase
  endfunction

  // Engine stand-in: registered busy for n cycles after the strobe, garbage result while busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      eng_busy <= 1'b0;
      eng_cnt  <= '0;
      eng_nq   <= '0;
      eng_fib  <= '0;
    end else if (eng_stb && !eng_busy) begin
      eng_cnt  <= eng_n;
      eng_nq   <= eng_n;
      eng_busy <= (eng_n != 0);
      eng_fib  <= (eng_n == 0) ? fib_ref(eng_n) : 32'hDEADBEEF;
    end else if (eng_busy) begin
      eng_cnt  <= eng_cnt - 1;
      eng_busy <= (eng_cnt != 1);
      if (eng_cnt == 1) eng_fib <= fib_ref(eng_nq);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic post(input int unsigned k, input int unsigned n);
    req[k] = 1'b1;
    nbus[k*W +: W] = W'(n);
    opm[k] = n;
  endtask

  task automatic maybe_add();
    for (int unsigned k = 0; k < NREQ; k++)
      if (!req[k] && $urandom_range(0, 3) == 0) post(k, $urandom_range(0, 6));
  endtask

  function automatic int unsigned exp_grant();
    for (int unsigned i = 0; i < NREQ; i++)
      if (req[(ptr_m + i) % NREQ]) return (ptr_m + i) % NREQ;
    return 0;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ptr_m = 0;
    jobs_m = 0;
  endtask

  // One job from grant to the cycle after o_done; called at a negedge while the scheduler is idle
  // or already showing the ack for the arbitration just made.
  task automatic serve(input bit hold, input bit rnd);
    int unsigned g, n, waits, cyc;
    bit saw_busy, had_req;
    g = exp_grant();
    n = opm[g];
    waits = 0;
    while (ack == '0 && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    check("ack", 64'(ack), 64'(1) << g);
    check("eng_stb", 64'(eng_stb), 1);
    check("eng_n", 64'(eng_n), 64'(n));
    check("busy_grant", 64'(busy), 1);
    if (!hold) req[g] = 1'b0;
    if (rnd) maybe_add();
    cyc = 0;
    saw_busy = 1'b0;
    while (done == '0 && cyc < n + 20) begin
      @(negedge clk);
      cyc++;
      saw_busy |= eng_busy;
      if (cyc == 1) begin
        check("ack_clr", 64'(ack), 0);
        check("stb_clr", 64'(eng_stb), 0);
      end
    end
    check("latency", 64'(cyc), 64'(n + 2));
    check("done", 64'(done), 64'(1) << g);
    check("result", 64'(result), 64'(fib_ref(W'(n))));
    if (n == 0) check("n0_eng_busy", 64'(saw_busy), 0);
    ptr_m = (g + 1) % NREQ;
    jobs_m++;
    if (rnd) maybe_add();
    had_req = |req;
    @(negedge clk);
    check("done_clr", 64'(done), 0);
    check("bubble", 64'(ack != '0), 64'(had_req));
  endtask

  initial begin
    bit early;
    req = '0;
    nbus = '0;
    ext_busy = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_ack", 64'(ack), 0);
    check("rst_done", 64'(done), 0);
    check("rst_result", 64'(result), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_stb", 64'(eng_stb), 0);
    check("rst_eng_n", 64'(eng_n), 0);

    post(1, 3);
    serve(0, 0);
    post(0, 0);
    serve(0, 0);

    do_reset();
    post(0, 1); post(1, 2); post(2, 0); post(3, 3);
    repeat (4) serve(0, 0);
    check("ptr_wrap_grant", 64'(exp_grant()), 0);

    post(3, 1); post(0, 1);
    repeat (4) serve(1, 0);
    req[3] = 1'b0;
    serve(0, 0);

    ext_busy = 1'b1;
    post(2, 1);
    early = 1'b0;
    repeat (5) begin
      @(negedge clk);
      early |= (ack != '0);
    end
    check("ext_busy_hold", 64'(early), 0);
    ext_busy = 1'b0;
    serve(0, 0);

    post(1, 3);
    while (ack == '0) @(negedge clk);
    req[1] = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ptr_m = 0;
    jobs_m = 0;
    check("rstw_busy", 64'(busy), 0);
    check("rstw_stb", 64'(eng_stb), 0);
    check("rstw_result", 64'(result), 0);
    early = 1'b0;
    repeat (6) begin
      early |= (done != '0);
      @(negedge clk);
    end
    check("rstw_no_done", 64'(early), 0);
    post(2, 2);
    serve(0, 0);

    repeat (150) begin
      if (req == '0) post($urandom_range(0, NREQ - 1), $urandom_range(0, 6));
      serve(0, 1);
    end
    while (req != '0) serve(0, 0);

`ifdef FIB_SCHED_STATS_EN
    check("job_cnt", 64'(job_cnt), 64'(jobs_m));
    do_reset();
    check("job_cnt_rst", 64'(job_cnt), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
